// File: rtl/amms_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amms_cmd_pkg
// Purpose  : Shared types and constants for the AMMS command engine: FSM state
//            encoding, command field positions, control bits, result/status
//            bit offsets and lane geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package amms_cmd_pkg;

  // State codes double as the status[109:108] state field.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_LANE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bus geometry
  localparam int CMD_W     = 131;
  localparam int RES_W     = 128;
  localparam int WORD_W    = 128;
  localparam int NUM_LANES = 4;

  // Command export fields: [130] wr_pulse, [129:128] addr, [127:0] wdata
  localparam int WR_BIT   = 130;
  localparam int ADDR_LSB = 128;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;

  // Control word fields
  localparam int START_BIT = 31;
  localparam int CLEAR_BIT = 30;
  localparam int N_W       = 16;

  // Result export field offsets
  localparam int RES_SUM_LSB  = 0;
  localparam int RES_XOR_LSB  = 32;
  localparam int RES_WD_LSB   = 64;
  localparam int RES_STAT_LSB = 96;

  // Offsets inside the 32-bit status field
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_ERR       = 3;
  localparam int STAT_LVL_LSB   = 4;
  localparam int STAT_STATE_LSB = 12;
  localparam int STAT_CYC_LSB   = 16;

endpackage
`default_nettype wire

// File: rtl/amms_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : amms_cmd_if
// Purpose  : Bundles the two HPS lightweight-bridge exports consumed by the
//            command engine.
// Signals  : cmd_in     [130:0] write export (wr_pulse, addr, wdata)
//            result_out [127:0] readback export (sum, xor, words_done, status)
// Modports : master - HPS side (drives cmd_in, reads result_out)
//            slave  - engine side (reads cmd_in, drives result_out)
// Revision : 1.0 - initial release
// ============================================================================
interface amms_cmd_if;
  import amms_cmd_pkg::*;

  logic [CMD_W-1:0] cmd_in;
  logic [RES_W-1:0] result_out;

  modport master (output cmd_in, input result_out);
  modport slave  (input cmd_in, output result_out);

endinterface
`default_nettype wire

// File: rtl/amms_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : amms_cmd_fifo
// Purpose  : Single-clock, show-ahead FIFO. head always presents the oldest
//            entry when not empty. A push to a full FIFO is dropped even if a
//            pop happens in the same cycle. flush empties it synchronously.
// Ports    : clk, rst           clock, synchronous active-high reset
//            flush              discard all entries
//            push, din          write request and data
//            pop                consume head (ignored when empty)
//            head               current oldest entry
//            full, empty, level occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module amms_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       flush,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           din,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           head,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/amms_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : amms_cmd_engine
// Purpose  : Decodes HPS bridge write commands into FIFO data pushes and
//            control (start/clear), then computes a lane-wise 32-bit sum and
//            XOR checksum over N buffered 128-bit words, one lane per cycle.
//            All results and status are returned on a registered readback.
// Ports    : clk_clk     system clock
//            reset_reset synchronous active-high reset
//            bus         amms_cmd_if.slave (cmd_in in, result_out out)
// Options  : AMMS_CMD_CYCLE_CNT_EN - when defined, status[127:112] carries a
//            saturating busy-cycle counter; otherwise it reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module amms_cmd_engine
  import amms_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LANE_W     = 32
) (
  input  wire logic   clk_clk,
  input  wire logic   reset_reset,
  amms_cmd_if.slave   bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic              wr_pulse;
  logic [1:0]        addr;
  logic [WORD_W-1:0] wdata;
  logic              push_req;
  logic              ctrl_wr;
  logic              clear_cmd;
  logic              start_cmd;
  logic              unused_ctrl_bits;

  assign wr_pulse  = bus.cmd_in[WR_BIT];
  assign addr      = bus.cmd_in[ADDR_LSB +: 2];
  assign wdata     = bus.cmd_in[WORD_W-1:0];
  assign push_req  = wr_pulse && (addr == ADDR_DATA);
  assign ctrl_wr   = wr_pulse && (addr == ADDR_CTRL);
  // Clear wins over a simultaneous start.
  assign clear_cmd = ctrl_wr && wdata[CLEAR_BIT];
  assign start_cmd = ctrl_wr && wdata[START_BIT] && !clear_cmd;
  assign unused_ctrl_bits = ^wdata[CLEAR_BIT-1:N_W];

  // ---------------------------------------------------------------- state
  state_t            state_q, state_nxt;
  logic [N_W-1:0]    n_q, n_nxt;
  logic [N_W-1:0]    wd_q, wd_nxt;
  logic [31:0]       sum_q, sum_nxt;
  logic [31:0]       xor_q, xor_nxt;
  logic [1:0]        lane_q, lane_nxt;
  logic [WORD_W-1:0] work_q, work_nxt;
  logic              ovf_q, ovf_nxt;
  logic              err_q, err_nxt;

  logic              busy_q;
  logic              start_ok;

  assign busy_q   = (state_q == ST_LOAD) || (state_q == ST_LANE);
  assign start_ok = start_cmd && !busy_q;

  // ---------------------------------------------------------------- FIFO
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              push_ok;
  logic              pop;
  logic [LVL_W-1:0]  level_nxt;

  assign pop     = (state_q == ST_LOAD) && !fifo_empty && !clear_cmd;
  assign push_ok = push_req && !fifo_full;

  amms_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .flush (clear_cmd),
    .push  (push_req),
    .din   (wdata),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // The readback shows post-edge values, so the FIFO level is predicted
  // here alongside the other next-state values.
  always_comb begin
    level_nxt = fifo_level;
    if (clear_cmd) begin
      level_nxt = '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   level_nxt = fifo_level + LVL_W'(1);
        2'b01:   level_nxt = fifo_level - LVL_W'(1);
        default: level_nxt = fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------- lanes
  logic [LANE_W-1:0] lanes [NUM_LANES];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lanes[gi] = work_q[gi*LANE_W +: LANE_W];
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state_q;
    n_nxt     = n_q;
    wd_nxt    = wd_q;
    sum_nxt   = sum_q;
    xor_nxt   = xor_q;
    lane_nxt  = lane_q;
    work_nxt  = work_q;
    ovf_nxt   = ovf_q || (push_req && fifo_full);
    err_nxt   = err_q || (start_cmd && busy_q);

    if (clear_cmd) begin
      state_nxt = ST_IDLE;
      wd_nxt    = '0;
      sum_nxt   = '0;
      xor_nxt   = '0;
      ovf_nxt   = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            n_nxt     = wdata[N_W-1:0];
            wd_nxt    = '0;
            sum_nxt   = '0;
            xor_nxt   = '0;
            state_nxt = (wdata[N_W-1:0] == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Stall here until a word is available.
          if (!fifo_empty) begin
            work_nxt  = fifo_head;
            lane_nxt  = 2'd0;
            state_nxt = ST_LANE;
          end
        end
        ST_LANE: begin
          sum_nxt  = sum_q + lanes[lane_q];
          xor_nxt  = xor_q ^ lanes[lane_q];
          lane_nxt = lane_q + 2'd1;
          if (lane_q == 2'(NUM_LANES - 1)) begin
            wd_nxt    = wd_q + N_W'(1);
            state_nxt = ((wd_q + N_W'(1)) == n_q) ? ST_DONE : ST_LOAD;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- cycle counter
  logic [15:0] cyc_nxt;

`ifdef AMMS_CMD_CYCLE_CNT_EN
  logic [15:0] cyc_q;

  always_comb begin
    cyc_nxt = cyc_q;
    if (clear_cmd || start_ok) begin
      cyc_nxt = '0;
    end else if (busy_q && (cyc_q != 16'hFFFF)) begin
      cyc_nxt = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) cyc_q <= '0;
    else             cyc_q <= cyc_nxt;
  end
`else
  assign cyc_nxt = '0;
`endif

  // ---------------------------------------------------------------- readback
  logic [7:0]       lvl8;
  logic [31:0]      status_nxt;
  logic [RES_W-1:0] result_nxt;

  always_comb begin
    lvl8             = '0;
    lvl8[LVL_W-1:0]  = level_nxt;

    status_nxt                           = '0;
    status_nxt[STAT_BUSY]                = (state_nxt == ST_LOAD) || (state_nxt == ST_LANE);
    status_nxt[STAT_DONE]                = (state_nxt == ST_DONE);
    status_nxt[STAT_OVF]                 = ovf_nxt;
    status_nxt[STAT_ERR]                 = err_nxt;
    status_nxt[STAT_LVL_LSB +: 8]        = lvl8;
    status_nxt[STAT_STATE_LSB +: 2]      = state_nxt;
    status_nxt[STAT_CYC_LSB +: 16]       = cyc_nxt;

    result_nxt                           = '0;
    result_nxt[RES_SUM_LSB +: 32]        = sum_nxt;
    result_nxt[RES_XOR_LSB +: 32]        = xor_nxt;
    result_nxt[RES_WD_LSB +: N_W]        = wd_nxt;
    result_nxt[RES_STAT_LSB +: 32]       = status_nxt;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      wd_q           <= '0;
      sum_q          <= '0;
      xor_q          <= '0;
      lane_q         <= '0;
      work_q         <= '0;
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
      bus.result_out <= '0;
    end else begin
      state_q        <= state_nxt;
      n_q            <= n_nxt;
      wd_q           <= wd_nxt;
      sum_q          <= sum_nxt;
      xor_q          <= xor_nxt;
      lane_q         <= lane_nxt;
      work_q         <= work_nxt;
      ovf_q          <= ovf_nxt;
      err_q          <= err_nxt;
      bus.result_out <= result_nxt;
    end
  end

endmodule
`default_nettype wire
